// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the unified-memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between CPU fetch and load/store; data wins unless fetch is starved.
//   state   | meaning
//   IDLE    | nothing in flight, arbitrate and grant
//   REQ     | m_req high with latched fields until m_gnt
//   WAIT_RD | waiting for m_rvalid of a load/fetch
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              pick_i, pick_d;
  logic              rd_done;

  // Outputs are forced low while rst is held, even if requests are asserted.
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (bus.i_req && starve_q == LIMIT) pick_i = 1'b1;
      else if (bus.d_req)                 pick_d = 1'b1;
      else if (bus.i_req)                 pick_i = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (pick_i) begin
          owner_d  = OWN_I;
          we_d     = 1'b0;
          addr_d   = bus.i_addr;
          wdata_d  = '0;
          starve_d = '0;
          state_d  = REQ;
        end else if (pick_d) begin
          owner_d = OWN_D;
          we_d    = bus.d_we;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          if (bus.i_req && starve_q != LIMIT) starve_d = starve_q + CNT_W'(1);
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.m_gnt) state_d = we_q ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.m_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      starve_q <= starve_d;
    end
  end

  assign rd_done = (state_q == WAIT_RD) && bus.m_rvalid && !rst;

  assign bus.i_gnt    = pick_i;
  assign bus.d_gnt    = pick_d;
  assign bus.i_rvalid = rd_done && (owner_q == OWN_I);
  assign bus.d_rvalid = rd_done && (owner_q == OWN_D);
  assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;

  assign bus.m_req   = (state_q == REQ);
  assign bus.m_we    = bus.m_req && we_q;
  assign bus.m_addr  = bus.m_req ? addr_q : '0;
  assign bus.m_wdata = bus.m_req ? wdata_q : '0;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one unified instruction/data memory between the pipelined CPU's fetch port and its MEM-stage load/store port. It accepts one request at a time from either requester and drives the single memory port. It returns read data to the owning requester. Data accesses normally win; an anti-starvation counter guarantees fetch progress. It sits between the CPU's `pc_out`/`inst` and `addr_out`/`data_out`/`data_in` ports and the memory.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive data grants allowed while a fetch request is pending before fetch is forced to win (range 1..15).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_req`  in  1  fetch request; held with `i_addr` stable until `i_gnt`.
- `i_addr`  in  32  fetch address.
- `i_gnt`  out  1  fetch request accepted this cycle.
- `i_rvalid`  out  1  fetch data valid.
- `i_rdata`  out  32  fetch data.
- `d_req`  in  1  data request; held with `d_we`, `d_addr`, `d_wdata` stable until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid.
- `d_rdata`  out  32  load data.
- `m_req`  out  1  memory request.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  32  memory address.
- `m_wdata`  out  32  memory write data.
- `m_gnt`  in  1  memory accepted the request this cycle.
- `m_rvalid`  in  1  memory read data valid; arrives at least 1 cycle after `m_gnt`.
- `m_rdata`  in  32  memory read data.

## Operation
States:
- IDLE: no transaction is in flight.
  - Arbitration:
    - If `starve_cnt == STARVE_LIMIT` and `i_req` is high, fetch wins.
    - Otherwise `d_req` wins over `i_req`.
  - The winner's `x_gnt` is asserted combinationally in this state.
  - At the clock edge, the arbiter latches the winner's addr/we/wdata into registers, records `owner`, and moves to REQ.
  - Fetch is always a read (`we`=0).
- REQ: `m_req`=1; `m_we`/`m_addr`/`m_wdata` are driven from the registers.
  - On `m_gnt`: a store goes to IDLE; a load or fetch goes to WAIT_RD.
- WAIT_RD: `m_req`=0.
  - On `m_rvalid`, assert `owner`'s `x_rvalid` with `x_rdata = m_rdata` combinationally, then go to IDLE.

Starvation counter (`starve_cnt`):
- Width is $clog2(STARVE_LIMIT+1).
- Increments on a data grant when `i_req` is also high; saturates at `STARVE_LIMIT`.
- Clears on any fetch grant.
- Holds on a data grant when `i_req` is low.

Boundary conditions:
- `m_rvalid` outside WAIT_RD is ignored.
- Requests raised while not in IDLE wait; no `x_gnt` is issued.
- `x_rdata` is 0 whenever `x_rvalid` is 0.
- Reset mid-transaction returns to IDLE and drops the in-flight access (memory shares `rst`).

## Timing
Reset values:
- State is IDLE; `starve_cnt` = 0; latched registers = 0.
- Outputs `m_req`, `m_we`, `m_addr`, `m_wdata`, `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid`, `i_rdata`, `d_rdata` are all 0.

Read latency, memory granting immediately and responding next cycle:
- cycle 0: `x_gnt`
- cycle 1: `m_req` and `m_gnt`
- cycle 2: `m_rvalid` and `x_rvalid`
- cycle 3: IDLE, and the next `x_gnt` is possible

Throughput:
- Loads and fetches: 1 access per 3 cycles minimum.
- Stores: 1 per 2 cycles (`x_gnt` in IDLE, `m_gnt` in REQ).

Protocol rules:
- `x_gnt` is a single-cycle pulse.
- `i_gnt` and `d_gnt` are never high together.
- `m_req` stays high with stable fields until `m_gnt`.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum {IDLE, REQ, WAIT_RD};
  - owner enum {OWN_I, OWN_D};
  - constant `ADDR_W` = 32 and `DATA_W` = 32.
- Single module; no sub-module warranted. The arbitration pick is a small always block.

## Test plan
- **Fetch read:** fetch read at 0x0000_0010, memory returns 0xDEAD_BEEF one cycle after `m_gnt` -> `i_rvalid`=1, `i_rdata`=0xDEAD_BEEF exactly 2 cycles after `i_gnt`; `d_rvalid` stays 0.
- **Simultaneous requests:** `i_req` and `d_req` (load 0x100) in the same cycle, `starve_cnt`=0 -> `d_gnt` first. The fetch is granted in the first IDLE after the load's `d_rvalid`, and `starve_cnt` goes 1 then 0.
- **Starvation:** `d_req` held continuously with `i_req` high, `STARVE_LIMIT`=4 -> 4 `d_gnt`, then `i_gnt` on the 5th arbitration, then data resumes.
- **Store with memory back-pressure:** store 0x1234_5678 to 0x200, `m_gnt` withheld 3 cycles -> `m_req`/`m_addr`/`m_wdata` stable for 4 cycles; IDLE next cycle after `m_gnt`; no `d_rvalid`.
- **Stray response:** `m_rvalid` pulsed while in IDLE or REQ -> no `x_rvalid`, no state change.
- **Reset mid-read:** `rst` asserted during WAIT_RD -> all outputs 0 immediately. After release, a new `i_req` gets `i_gnt` in the first cycle, and a late `m_rvalid` from the aborted access is ignored.
